// File: rtl/cpu_pkg.sv
// Shared types and default widths for the basic processor front end.
package cpu_pkg;

  localparam int unsigned CPU_OP_W = 3;
  localparam int unsigned CPU_IR_W = 8;
  localparam int unsigned CPU_PC_W = 5;

  typedef enum logic {
    StIdle,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic                valid;
    logic [CPU_PC_W-1:0] addr;
    logic [CPU_IR_W-1:0] data;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_buf.sv
// One-entry prefetch buffer: holds a speculatively fetched word and compares its address.
// Uses the package default widths; only built into fetch_unit under FETCH_PREFETCH_EN.
module prefetch_buf
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                n_reset,
  input  logic                fill,
  input  logic                inv,
  input  logic [CPU_PC_W-1:0] fill_addr,
  input  logic [CPU_IR_W-1:0] fill_data,
  input  logic [CPU_PC_W-1:0] hit_addr,
  input  logic [CPU_PC_W-1:0] want_addr,
  output logic                hit,
  output logic                present,
  output logic [CPU_IR_W-1:0] data
);

  pf_entry_t ent_q;

  assign hit     = ent_q.valid && (ent_q.addr == hit_addr);
  assign present = ent_q.valid && (ent_q.addr == want_addr);
  assign data    = ent_q.data;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ent_q <= '0;
    end else if (fill) begin
      ent_q <= '{valid: 1'b1, addr: fill_addr, data: fill_data};
    end else if (inv) begin
      ent_q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC/IR, req/ack memory port with timeout, combinational hold.
// Define FETCH_PREFETCH_EN to add a one-entry speculative prefetch buffer.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned OP_W    = CPU_OP_W,
  parameter int unsigned IR_W    = CPU_IR_W,
  parameter int unsigned PC_W    = CPU_PC_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic            load_IR,
  input  logic            load_PC,
  input  logic            INC_PC,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [IR_W-1:0] imem_rdata,
  output logic [OP_W-1:0] op,
  output logic [IR_W-1:0] ir,
  output logic [PC_W-1:0] pc,
  output logic            hold,
  output logic            fetch_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q, addr_q;
  logic [IR_W-1:0] ir_q, ir_next;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            start, timeout, ir_load, to_wait, to_idle, pc_upd, buf_hit;

  // A simultaneous load_PC wins over load_IR.
  assign start   = load_IR & ~load_PC;
  assign timeout = imem_req & ~imem_ack & (cnt_q == CntW'(TIMEOUT - 1));
  assign pc_upd  = load_PC & ~hold;

`ifdef FETCH_PREFETCH_EN
  logic            pf_q, cur_q, buf_present, buf_fill, buf_inv;
  logic [PC_W-1:0] pf_target;
  logic [IR_W-1:0] buf_data;

  // Once IR holds the word at PC, the next useful word is PC+1.
  assign pf_target = cur_q ? pc_q + 1'b1 : pc_q;

  prefetch_buf u_prefetch_buf (
    .clock     (clock),
    .n_reset   (n_reset),
    .fill      (buf_fill),
    .inv       (buf_inv),
    .fill_addr (imem_addr),
    .fill_data (imem_rdata),
    .hit_addr  (pc_q),
    .want_addr (pf_target),
    .hit       (buf_hit),
    .present   (buf_present),
    .data      (buf_data)
  );
`else
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    hold      = 1'b0;
    ir_load   = 1'b0;
    ir_next   = imem_rdata;
    to_wait   = 1'b0;
    to_idle   = 1'b0;
`ifdef FETCH_PREFETCH_EN
    buf_fill  = 1'b0;
    buf_inv   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !buf_hit) begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load = 1'b1;
          end else begin
            hold    = 1'b1;
            to_wait = 1'b1;
          end
        end
`ifdef FETCH_PREFETCH_EN
        else if (start) begin
          ir_load = 1'b1;
          ir_next = buf_data;
          buf_inv = 1'b1;
        end else if (!load_PC && !err_q && !buf_present) begin
          imem_req  = 1'b1;
          imem_addr = pf_target;
          if (imem_ack) buf_fill = 1'b1;
          else          to_wait  = 1'b1;
        end
`endif
      end
      StWait: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
`ifdef FETCH_PREFETCH_EN
        if (pf_q) begin
          // A prefetch for the wrong address is dropped; IDLE then refetches PC.
          hold = load_IR & ~(imem_ack & (addr_q == pc_q));
          if (imem_ack) begin
            to_idle = 1'b1;
            if (!load_IR)              buf_fill = 1'b1;
            else if (addr_q == pc_q)   ir_load  = 1'b1;
          end
        end else
`endif
        begin
          hold = load_IR & ~imem_ack;
          if (imem_ack) begin
            ir_load = 1'b1;
            to_idle = 1'b1;
          end
        end
      end
    endcase
    if (timeout) hold = 1'b0;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (pc_upd) pc_q <= INC_PC ? pc_q + 1'b1 : ir_q[PC_W-1:0];
      if (timeout) begin
        ir_q    <= '0;
        err_q   <= 1'b1;
        cnt_q   <= '0;
        state_q <= StIdle;
      end else begin
        if (ir_load) ir_q <= ir_next;
        if (to_wait) begin
          state_q <= StWait;
          addr_q  <= imem_addr;
        end else if (to_idle) begin
          state_q <= StIdle;
        end
        if (imem_req) cnt_q <= imem_ack ? '0 : cnt_q + 1'b1;
      end
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pf_q  <= 1'b0;
      cur_q <= 1'b0;
    end else begin
      if (to_wait) pf_q <= ~start;
      if (pc_upd)                   cur_q <= 1'b0;
      else if (ir_load && !timeout) cur_q <= 1'b1;
    end
  end
`endif

  assign op        = ir_q[IR_W-1 -: OP_W];
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the basic processor. Holds the program counter (PC) and instruction register (IR), and executes the decoder's `load_IR`, `load_PC` and `INC_PC` strobes. Fetches instruction words over a variable-latency req/ack memory port and returns a combinational `hold` so the decoder stays in fetch until the word arrives. Feeds `op` (the IR opcode field) back to the decoder.

## Interface
- `OP_W`, 3: opcode field width; `op` = IR[IR_W-1 -: OP_W].
- `IR_W`, 8: instruction word width.
- `PC_W`, 5: address width; branch target = IR[PC_W-1:0]; requires PC_W <= IR_W-OP_W.
- `TIMEOUT`, 15: maximum consecutive unacknowledged request cycles before an error.

Ports:
- `clock` in 1: single clock, rising edge.
- `n_reset` in 1: asynchronous, active-low reset.
- `load_IR` in 1: decoder fetch strobe.
- `load_PC` in 1: PC update strobe.
- `INC_PC` in 1: with `load_PC`, 1 = PC+1, 0 = branch.
- `imem_req` out 1: memory request.
- `imem_addr` out PC_W: request address.
- `imem_ack` in 1: data valid this cycle; ignored while `imem_req`=0.
- `imem_rdata` in IR_W: instruction word.
- `op` out OP_W: current opcode.
- `ir` out IR_W: full IR.
- `pc` out PC_W: current PC.
- `hold` out 1: combinational; decoder must not advance.
- `fetch_err` out 1: sticky timeout flag.

## Operation
- Reset values: PC=0, IR=0, `imem_req`=0, `imem_addr`=0, `hold`=0, `fetch_err`=0, wait counter=0, FSM=IDLE, prefetch buffer invalid.
- FSM states are IDLE and WAIT.
- IDLE + `load_IR`:
  - Drive `imem_req`=1 and `imem_addr`=PC combinationally.
  - If `imem_ack` is 1: IR <= `imem_rdata`, `hold`=0, stay in IDLE.
  - Otherwise: `hold`=1, go to WAIT.
- WAIT:
  - `imem_req`=1, with the address registered and stable until ack.
  - `hold`=`load_IR`&!`imem_ack`.
  - On ack: load IR, go to IDLE.
- Handshake rule: once raised, `imem_req` and `imem_addr` do not change until the ack cycle.
- Timeout:
  - The wait counter increments every cycle with `imem_req`&!`imem_ack` and clears on ack.
  - When it reaches TIMEOUT: IR <= 0, `fetch_err` <= 1, `hold` released, request dropped, state IDLE.
  - `fetch_err` clears only on reset.
- PC update:
  - `load_PC`&`INC_PC`: PC <= PC+1, mod 2^PC_W, so PC wraps from all-ones to 0.
  - `load_PC`&!`INC_PC`: PC <= IR[PC_W-1:0].
  - `load_PC` is ignored while `hold`=1.
- Simultaneous `load_IR` and `load_PC`: the decoder never issues this combination. If it occurs, `load_PC` takes priority and `load_IR` is ignored.
- Reset mid-request: the request is abandoned immediately. A late `imem_ack` after reset is ignored because `imem_req`=0.

## Timing
- Zero-wait memory (ack in the request cycle): IR is valid on the next edge, `hold` is never asserted, and one instruction completes per 2 cycles.
- N-cycle memory latency: `hold` is high for N cycles, and IR updates on the edge ending the ack cycle.
- `op`, `ir` and `pc` are registered outputs. `hold` and `imem_req` depend combinationally on `load_IR`, `imem_ack` and the state.

## Configuration
- `FETCH_PREFETCH_EN` undefined: behaviour is exactly as above; no speculative requests are made.
- `FETCH_PREFETCH_EN` defined: adds a one-entry buffer {valid, addr, data}.
  - In IDLE with no `load_IR`, the unit issues a request for PC+1, or for PC if the buffer address is stale. On ack it fills the buffer.
  - On `load_IR`, if the buffer is valid and its address equals PC: IR <= buffer data, no memory request is made, `hold`=0, and the buffer is invalidated.
  - On `load_IR` during an outstanding prefetch:
    - If the prefetch address equals PC, the ack loads IR directly.
    - Otherwise the data is discarded and a new request for PC follows the next cycle, with `hold` kept high.
  - A branch to a non-matching address leaves the buffer to miss by address compare; no explicit flush is needed.

## Structure
- Shared `cpu_pkg` holds:
  - The fetch FSM state enum.
  - Default width constants (OP_W, IR_W, PC_W).
  - The prefetch buffer entry struct.
- One sub-module, `prefetch_buf`: the buffer entry, address compare and fill logic. It is instantiated only under `FETCH_PREFETCH_EN`.

## Test plan
- Reset with zero-wait memory returning 8'hA5 at address 0, then `load_IR` → IR=8'hA5, `op`=3'b101, `hold` never high.
- Memory with 3-cycle ack latency → `hold` high for exactly 3 cycles, `imem_addr` stable throughout, IR updates after the ack cycle.
- PC=5'h1F with `load_PC`&`INC_PC` → PC=0. With IR=8'hE9, `load_PC`&!`INC_PC` → PC=5'h09.
- Ack never arrives → after 15 request cycles `fetch_err`=1, IR=0, `hold`=0. `fetch_err` remains set until `n_reset` is pulsed.
- `n_reset` asserted during WAIT → `imem_req`=0 immediately; an ack one cycle later leaves IR=0.
- With `FETCH_PREFETCH_EN` defined: sequential fetches at PC 0,1,2 → second and later `load_IR` have `hold`=0 and no request in the load cycle. A branch to 5'h10 → buffer miss, `hold` asserted, fetch from 5'h10.
